output_buffer_ctrl: RTL and testbench

OUTPUT_BUFFER_CTRL -- requirements
Module: output_buffer_ctrl

---
 rtl/output_buffer_ctrl_pkg.sv | 27 ++
 rtl/output_buffer_beat_cnt.sv | 44 ++++
 rtl/output_buffer_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_output_buffer_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/output_buffer_ctrl_pkg.sv
// Shared constants and types for the output buffer controller: pim mode codes,
// FSM state encoding and readout beat count.
package output_buffer_ctrl_pkg;

    localparam logic [2:0] PIM_READ     = 3'b011;
    localparam logic [2:0] PIM_PARALLEL = 3'b101;
    localparam logic [2:0] PIM_RBR      = 3'b110;

    localparam int unsigned BEAT_CNT   = 32;
    localparam int unsigned BEAT_CNT_W = $clog2(BEAT_CNT);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CAP1   = 3'd1,
        ST_CAP2   = 3'd2,
        ST_PROC   = 3'd3,
        ST_ZP     = 3'd4,
        ST_RD_CAP = 3'd5,
        ST_LOAD   = 3'd6,
        ST_DONE   = 3'd7
    } obc_state_e;

    function automatic logic is_burst_mode(input logic [2:0] mode);
        return (mode == PIM_PARALLEL) || (mode == PIM_RBR);
    endfunction

endpackage

// File: rtl/output_buffer_beat_cnt.sv
// Purpose: 5-bit readout beat countdown; clear beats load beats decrement.
// Latency: value updates on the clock edge after the control input.
// Backpressure: holds its value whenever dec_i is low (stalled beat).
module output_buffer_beat_cnt
    import output_buffer_ctrl_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  load_i,
    input  logic                  dec_i,
    input  logic                  clr_i,
    output logic [BEAT_CNT_W-1:0] cnt_o,
    output logic                  zero_o
);

    localparam logic [BEAT_CNT_W-1:0] CNT_TOP = BEAT_CNT_W'(BEAT_CNT - 1);
    localparam logic [BEAT_CNT_W-1:0] CNT_ONE = BEAT_CNT_W'(1);

    logic [BEAT_CNT_W-1:0] cnt_d, cnt_q;

    // Saturating at zero: the last beat exits LOAD rather than wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = CNT_TOP;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/output_buffer_ctrl.sv
// Purpose: sequences eFlash output capture, processing and 32/1-beat readout; OUTPUT_BUFFER_CTRL_ZP_EN adds a zero-point step.
// Latency: every strobe is registered, appearing the cycle after its triggering state/event.
// Backpressure: rd_ready_i low holds load_en_o and load_cnt_o; abort_i returns to IDLE next cycle.
module output_buffer_ctrl
    import output_buffer_ctrl_pkg::*;
#(
    parameter int unsigned PROC_CYCLES = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic [2:0]         pim_mode_i,
    input  logic [8:0]         col_addr9_i,
    input  logic               adc_valid_i,
    input  logic               rd_ready_i,
    input  logic               abort_i,
    input  logic signed [31:0] zp_data_i,
    output logic [2:0]         pim_mode_o,
    output logic [2:0]         before_load_mode_o,
    output logic [8:0]         col_addr9_o,
    output logic               pim_out_buf_w_en_1_o,
    output logic               pim_out_buf_w_en_2_o,
    output logic               pim_out_buf_r_en_o,
    output logic               read_mode_buf_w_en_o,
    output logic               zp_en_o,
    output logic signed [31:0] zp_data_o,
    output logic               load_en_o,
    output logic [4:0]         load_cnt_o,
    output logic               output_processing_done_o,
    output logic               busy_o,
    output logic               err_o
);

    localparam logic [3:0] PROC_LAST = 4'(PROC_CYCLES - 1);

    obc_state_e state_d, state_q;
    logic [3:0] proc_cnt_d, proc_cnt_q;
    logic [2:0] mode_d, mode_q;
    logic [8:0] col_d, col_q;
    logic       w_en_1_d, w_en_1_q;
    logic       w_en_2_d, w_en_2_q;
    logic       r_en_d, r_en_q;
    logic       rd_w_en_d, rd_w_en_q;
    logic       load_en_d, load_en_q;
    logic       done_d, done_q;
    logic       err_d, err_q;
`ifdef OUTPUT_BUFFER_CTRL_ZP_EN
    logic signed [31:0] zp_d, zp_q;
    logic               zp_en_d, zp_en_q;
`endif

    logic                  cnt_load, cnt_dec, cnt_clr, cnt_zero;
    logic [BEAT_CNT_W-1:0] cnt_val;

    output_buffer_beat_cnt u_beat_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load_i (cnt_load),
        .dec_i  (cnt_dec),
        .clr_i  (cnt_clr),
        .cnt_o  (cnt_val),
        .zero_o (cnt_zero)
    );

    always_comb begin
        state_d    = state_q;
        proc_cnt_d = proc_cnt_q;
        mode_d     = mode_q;
        col_d      = col_q;
        w_en_1_d   = 1'b0;
        w_en_2_d   = 1'b0;
        r_en_d     = 1'b0;
        rd_w_en_d  = 1'b0;
        load_en_d  = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        cnt_clr    = 1'b0;
`ifdef OUTPUT_BUFFER_CTRL_ZP_EN
        zp_d       = zp_q;
        zp_en_d    = 1'b0;
`endif
        // Abort wins over any start, capture or beat in the same cycle.
        if ((state_q != ST_IDLE) && abort_i) begin
            state_d    = ST_IDLE;
            proc_cnt_d = '0;
            cnt_clr    = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        if (is_burst_mode(pim_mode_i) || (pim_mode_i == PIM_READ)) begin
                            mode_d  = pim_mode_i;
                            col_d   = col_addr9_i;
`ifdef OUTPUT_BUFFER_CTRL_ZP_EN
                            zp_d    = zp_data_i;
`endif
                            state_d = (pim_mode_i == PIM_READ) ? ST_RD_CAP : ST_CAP1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                ST_CAP1: begin
                    if (adc_valid_i) begin
                        w_en_1_d = 1'b1;
                        state_d  = ST_CAP2;
                    end
                end
                ST_CAP2: begin
                    if (adc_valid_i) begin
                        w_en_2_d   = 1'b1;
                        r_en_d     = 1'b1;
                        proc_cnt_d = '0;
                        state_d    = ST_PROC;
                    end
                end
                ST_PROC: begin
                    if (proc_cnt_q == PROC_LAST) begin
                        proc_cnt_d = '0;
`ifdef OUTPUT_BUFFER_CTRL_ZP_EN
                        zp_en_d    = 1'b1;
                        state_d    = ST_ZP;
`else
                        load_en_d  = 1'b1;
                        cnt_load   = 1'b1;
                        state_d    = ST_LOAD;
`endif
                    end else begin
                        proc_cnt_d = proc_cnt_q + 4'd1;
                        r_en_d     = 1'b1;
                    end
                end
`ifdef OUTPUT_BUFFER_CTRL_ZP_EN
                ST_ZP: begin
                    load_en_d = 1'b1;
                    cnt_load  = 1'b1;
                    state_d   = ST_LOAD;
                end
`endif
                ST_RD_CAP: begin
                    if (adc_valid_i) begin
                        rd_w_en_d = 1'b1;
                        load_en_d = 1'b1;
                        cnt_clr   = 1'b1;
                        state_d   = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // Read mode enters with the count cleared, so the same zero test gives one beat.
                    load_en_d = 1'b1;
                    if (rd_ready_i) begin
                        if (cnt_zero) begin
                            load_en_d = 1'b0;
                            done_d    = 1'b1;
                            state_d   = ST_DONE;
                        end else begin
                            cnt_dec = 1'b1;
                        end
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            proc_cnt_q <= '0;
            mode_q     <= '0;
            col_q      <= '0;
            w_en_1_q   <= 1'b0;
            w_en_2_q   <= 1'b0;
            r_en_q     <= 1'b0;
            rd_w_en_q  <= 1'b0;
            load_en_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef OUTPUT_BUFFER_CTRL_ZP_EN
            zp_q       <= '0;
            zp_en_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            proc_cnt_q <= proc_cnt_d;
            mode_q     <= mode_d;
            col_q      <= col_d;
            w_en_1_q   <= w_en_1_d;
            w_en_2_q   <= w_en_2_d;
            r_en_q     <= r_en_d;
            rd_w_en_q  <= rd_w_en_d;
            load_en_q  <= load_en_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef OUTPUT_BUFFER_CTRL_ZP_EN
            zp_q       <= zp_d;
            zp_en_q    <= zp_en_d;
`endif
        end
    end

`ifdef OUTPUT_BUFFER_CTRL_ZP_EN
    assign zp_en_o   = zp_en_q;
    assign zp_data_o = zp_q;
`else
    logic unused_zp;
    assign unused_zp = ^zp_data_i;
    assign zp_en_o   = 1'b0;
    assign zp_data_o = '0;
`endif

    assign pim_mode_o               = mode_q;
    assign before_load_mode_o       = mode_q;
    assign col_addr9_o              = col_q;
    assign pim_out_buf_w_en_1_o     = w_en_1_q;
    assign pim_out_buf_w_en_2_o     = w_en_2_q;
    assign pim_out_buf_r_en_o       = r_en_q;
    assign read_mode_buf_w_en_o     = rd_w_en_q;
    assign load_en_o                = load_en_q;
    assign load_cnt_o               = cnt_val;
    assign output_processing_done_o = done_q;
    assign busy_o                   = (state_q != ST_IDLE);
    assign err_o                    = err_q;

endmodule

// File: tb/tb_output_buffer_ctrl.sv
// Bench for output_buffer_ctrl: mode-decode table, directed corner sequences and
// randomized full sequences checked against an event-level expectation model.
module tb_output_buffer_ctrl;
    import output_buffer_ctrl_pkg::*;

    localparam int PC = 4;
`ifdef OUTPUT_BUFFER_CTRL_ZP_EN
    localparam int ZP_ON = 1;
`else
    localparam int ZP_ON = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n, start, adc, rdy, abort;
    logic [2:0]         mode;
    logic [8:0]         col;
    logic signed [31:0] zp;
    logic [2:0]         pim_mode_o, bl_mode_o;
    logic [8:0]         col_o;
    logic               w1_o, w2_o, ren_o, rmb_o, zpen_o, load_en_o, done_o, busy_o, err_o;
    logic signed [31:0] zp_o;
    logic [4:0]         load_cnt_o;

    output_buffer_ctrl #(.PROC_CYCLES(PC)) u_dut (
        .clk_i                    (clk),
        .rst_ni                   (rst_n),
        .start_i                  (start),
        .pim_mode_i               (mode),
        .col_addr9_i              (col),
        .adc_valid_i              (adc),
        .rd_ready_i               (rdy),
        .abort_i                  (abort),
        .zp_data_i                (zp),
        .pim_mode_o               (pim_mode_o),
        .before_load_mode_o       (bl_mode_o),
        .col_addr9_o              (col_o),
        .pim_out_buf_w_en_1_o     (w1_o),
        .pim_out_buf_w_en_2_o     (w2_o),
        .pim_out_buf_r_en_o       (ren_o),
        .read_mode_buf_w_en_o     (rmb_o),
        .zp_en_o                  (zpen_o),
        .zp_data_o                (zp_o),
        .load_en_o                (load_en_o),
        .load_cnt_o               (load_cnt_o),
        .output_processing_done_o (done_o),
        .busy_o                   (busy_o),
        .err_o                    (err_o)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [8:0] strobes();
        return {busy_o, err_o, w1_o, w2_o, ren_o, rmb_o, zpen_o, load_en_o, done_o};
    endfunction

    // One full sequence. Expectations come from the mode's event recipe:
    // capture pulses, PC read cycles, optional zero-point, 32 (or 1) beats counting down, one done.
    task automatic run_seq(input logic [2:0] m, input logic [8:0] c, input logic [31:0] z,
                           input bit fixed_adc, input bit rnd, input int stall_val);
        bit   is_rd, finished, stall_done, prev_stall;
        int   n_w1, n_w2, n_ren, n_rmb, n_zp, n_done, n_err, beats, exp_idx, stall_left;
        int   c_w1, c_w2, c_ren0, c_ren1, c_rmb, c_zp, c_load0, c_last, c_done;
        logic [4:0] prev_cnt;
        is_rd = (m == PIM_READ);
        finished = 0; stall_done = 0; prev_stall = 0; prev_cnt = '0;
        n_w1 = 0; n_w2 = 0; n_ren = 0; n_rmb = 0; n_zp = 0; n_done = 0; n_err = 0; beats = 0;
        c_w1 = -1; c_w2 = -1; c_ren0 = -1; c_ren1 = -1; c_rmb = -1; c_zp = -1; c_load0 = -1;
        c_last = -1; c_done = -1; stall_left = 0;
        exp_idx = is_rd ? 0 : BEAT_CNT - 1;
        start = 1'b1; mode = m; col = c; zp = z; adc = 1'b0; rdy = 1'b0;
        step();
        for (int t = 1; t < 400; t++) begin
            if (prev_stall) begin
                chk("stall_hold_en", load_en_o, 1);
                chk("stall_hold_cnt", load_cnt_o, prev_cnt);
            end
            if (w1_o)  begin n_w1++; c_w1 = t; end
            if (w2_o)  begin n_w2++; c_w2 = t; end
            if (ren_o) begin if (n_ren == 0) c_ren0 = t; c_ren1 = t; n_ren++; end
            if (rmb_o) begin n_rmb++; c_rmb = t; end
            if (zpen_o) begin n_zp++; c_zp = t; end
            if (err_o) n_err++;
            if (load_en_o && c_load0 < 0) c_load0 = t;
            if (done_o) begin n_done++; c_done = t; finished = 1; end
            if (finished) break;
            adc = fixed_adc ? (t == 3 || t == 6) : ($urandom_range(0, 2) == 0);
            if (stall_left > 0) begin
                rdy = 1'b0; stall_left--;
            end else if (!stall_done && stall_val >= 0 && load_en_o && load_cnt_o == 5'(stall_val)) begin
                rdy = 1'b0; stall_left = 4; stall_done = 1;
            end else begin
                rdy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            start = rnd && ($urandom_range(0, 7) == 0);
            if (start) mode = 3'($urandom);
            if (load_en_o && rdy) begin
                chk("beat_idx", load_cnt_o, exp_idx);
                exp_idx--; beats++; c_last = t;
            end
            prev_stall = load_en_o && !rdy;
            prev_cnt   = load_cnt_o;
            step();
        end
        start = 1'b0; adc = 1'b0; rdy = 1'b0;
        chk("seq_timeout", finished, 1);
        chk("n_w1", n_w1, is_rd ? 0 : 1);
        chk("n_w2", n_w2, is_rd ? 0 : 1);
        chk("n_ren", n_ren, is_rd ? 0 : PC);
        chk("n_rmb", n_rmb, is_rd ? 1 : 0);
        chk("n_zp", n_zp, is_rd ? 0 : ZP_ON);
        chk("n_err", n_err, 0);
        chk("n_beats", beats, is_rd ? 1 : BEAT_CNT);
        chk("n_done", n_done, 1);
        chk("done_after_last_beat", c_done, c_last + 1);
        if (!is_rd) begin
            chk("cap_order", c_w1 < c_w2, 1);
            chk("ren_start", c_ren0, c_w2);
            chk("ren_consecutive", c_ren1 - c_ren0 + 1, PC);
            chk("zp_cycle", c_zp, ZP_ON ? c_ren1 + 1 : -1);
            chk("load_start", c_load0, c_ren1 + 1 + ZP_ON);
        end else begin
            chk("rd_load_start", c_load0, c_rmb);
        end
        if (fixed_adc) chk("first_cap_cycle", is_rd ? c_rmb : c_w1, 4);
        if (fixed_adc && !is_rd) chk("w2_cycle", c_w2, 7);
        chk("mode_o", pim_mode_o, m);
        chk("before_load_mode_o", bl_mode_o, m);
        chk("col_o", col_o, c);
        chk("zp_o", zp_o, ZP_ON ? z : 0);
        step();
        chk("post_done_idle", {busy_o, done_o}, 2'b00);
        chk("post_done_mode_held", pim_mode_o, m);
    endtask

    typedef struct {
        logic [2:0] m;
        logic       exp_err;
        logic       exp_busy;
    } vec_t;

    vec_t vt[8];

    initial begin
        int n;
        vt[0] = '{3'b000, 1'b1, 1'b0};
        vt[1] = '{3'b001, 1'b1, 1'b0};
        vt[2] = '{3'b010, 1'b1, 1'b0};
        vt[3] = '{3'b011, 1'b0, 1'b1};
        vt[4] = '{3'b100, 1'b1, 1'b0};
        vt[5] = '{3'b101, 1'b0, 1'b1};
        vt[6] = '{3'b110, 1'b0, 1'b1};
        vt[7] = '{3'b111, 1'b1, 1'b0};

        rst_n = 1'b0; start = 1'b0; mode = '0; col = '0; adc = 1'b0;
        rdy = 1'b0; abort = 1'b0; zp = '0;
        step(); step();
        chk("rst_strobes", strobes(), 9'h000);
        chk("rst_cnt", load_cnt_o, 0);
        chk("rst_latched", {pim_mode_o, bl_mode_o, col_o, zp_o}, 0);
        rst_n = 1'b1;
        step();
        chk("idle_strobes", strobes(), 9'h000);

        // Mode decode from IDLE
        for (int i = 0; i < 8; i++) begin
            start = 1'b1; mode = vt[i].m; col = 9'(i);
            step();
            start = 1'b0;
            chk("tbl_err", err_o, vt[i].exp_err);
            chk("tbl_busy", busy_o, vt[i].exp_busy);
            if (vt[i].exp_busy) begin
                chk("tbl_mode_latched", pim_mode_o, vt[i].m);
                abort = 1'b1;
                step();
                abort = 1'b0;
                chk("tbl_abort_idle", busy_o, 0);
            end else begin
                step();
                chk("tbl_err_one_cycle", {err_o, busy_o}, 2'b00);
            end
        end

        // Directed full sequences
        run_seq(PIM_PARALLEL, 9'h055, 32'sd1234, 1, 0, -1);
        run_seq(PIM_READ, 9'h1A5, -32'sd7, 1, 0, -1);
        run_seq(PIM_RBR, 9'h0F0, 32'sh7fff0001, 0, 0, 17);

        // Abort during PROC with a simultaneous start
        start = 1'b1; mode = PIM_PARALLEL; col = 9'h011;
        step();
        start = 1'b0; adc = 1'b1;
        n = 0;
        while (!ren_o && n < 20) begin step(); n++; end
        chk("abort_reach_proc", ren_o, 1);
        adc = 1'b0; abort = 1'b1; start = 1'b1; mode = PIM_RBR;
        step();
        abort = 1'b0; start = 1'b0; adc = 1'b1; rdy = 1'b1;
        chk("abort_strobes", strobes(), 9'h000);
        chk("abort_cnt", load_cnt_o, 0);
        n = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (busy_o || done_o) n++;
        end
        chk("abort_stays_idle", n, 0);
        adc = 1'b0; rdy = 1'b0;

        // Illegal mode keeps the block idle
        start = 1'b1; mode = 3'b000;
        step();
        start = 1'b0;
        chk("bad_mode_err", {err_o, busy_o}, 2'b10);
        n = 0;
        for (int k = 0; k < 4; k++) begin step(); if (busy_o || err_o) n++; end
        chk("bad_mode_quiet", n, 0);

        // Reset during LOAD
        start = 1'b1; mode = PIM_PARALLEL; col = 9'h1FF; zp = -32'sd1;
        step();
        start = 1'b0; adc = 1'b1; rdy = 1'b0;
        n = 0;
        while (!load_en_o && n < 40) begin step(); n++; end
        chk("rst_reach_load", load_en_o, 1);
        rst_n = 1'b0; rdy = 1'b1;
        step();
        rst_n = 1'b1; adc = 1'b0;
        chk("rst_load_strobes", strobes(), 9'h000);
        chk("rst_load_outs", {pim_mode_o, bl_mode_o, col_o, zp_o, load_cnt_o}, 0);
        n = 0;
        for (int k = 0; k < 6; k++) begin step(); if (busy_o || done_o) n++; end
        chk("rst_no_done", n, 0);
        rdy = 1'b0;

        // Randomized sequences with backpressure and ignored starts
        for (int r = 0; r < 8; r++) begin
            logic [2:0] rm;
            case ($urandom_range(0, 2))
                0:       rm = PIM_READ;
                1:       rm = PIM_PARALLEL;
                default: rm = PIM_RBR;
            endcase
            run_seq(rm, 9'($urandom), 32'($urandom), 0, 1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
